wb_unit: RTL and testbench
==========================

# wb_unit

Register-file write-back unit for the RV32I core: the single driver of the register file's write port (`d`, `addr`, `we`). It accepts completed results from the ALU and load paths over valid/ready handshakes, arbitrates between them with a starvation guard, and aligns and extends load data. It suppresses writes to x0 and issues one registered write per cycle.

## Interface
- `XLEN`, 32: data width.
- `STARVE_MAX`, 4: consecutive ALU-losing cycles before the ALU is granted priority; range 1..15.
- `CNT_W`, 32: retire counter width.

- `clk` in 1: clock, rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `alu_valid` in 1: ALU result offered.
- `alu_ready` out 1: ALU result accepted this cycle.
- `alu_rd` in 5: destination register.
- `alu_data` in XLEN: result.
- `ld_valid` in 1: load result offered.
- `ld_ready` out 1: load result accepted this cycle.
- `ld_rd` in 5: destination register.
- `ld_funct3` in 3: load type.
- `ld_addr_lo` in 2: effective address bits [1:0].
- `ld_rdata` in XLEN: raw aligned memory word.
- `we` out 1: register file write enable.
- `addr` out 5: register file write address.
- `d` out XLEN: register file write data.
- `ld_err` out 1: one-cycle pulse for an illegal funct3 or a misaligned load.
- `retire_cnt` out CNT_W: count of accepted results.

## Operation
- **Ready signals:** combinational from the valids and the arbiter state. There is no backpressure from the register file.
- **Arbitration, default:** load has priority. If both channels are valid, `ld_ready`=1 and `alu_ready`=0.
- **Starvation counter:** `starve` is 4 bits.
  - Increments on each cycle where `alu_valid`=1 and the ALU loses.
  - Clears on any cycle where the ALU is accepted or `alu_valid`=0.
  - When `starve`==STARVE_MAX, the ALU wins the next contested cycle, then `starve` clears.
- **Load formatting:** lane select by `ld_addr_lo`.
  - 000 LB: byte, sign-extended.
  - 001 LH: halfword at `ld_addr_lo[1]`, sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: halfword, zero-extended.
- **Load errors:** any other funct3, LH/LHU with `ld_addr_lo[0]`=1, or LW with `ld_addr_lo`≠0.
  - The load is still accepted.
  - No write is issued; `ld_err` pulses instead.
- **x0:** an accepted result with rd=0 is counted but produces `we`=0.
- **`retire_cnt`:** increments by 1 per accepted handshake, including x0 results and errored loads. It wraps modulo 2^CNT_W.

## Timing
- **Acceptance:** a handshake completes at the rising edge where valid&ready=1.
- **Write latency:** 1 cycle. Results accepted at edge N drive `we`/`addr`/`d` during cycle N+1.
  - `we` is high for exactly one cycle per write.
  - `addr`/`d` hold their last values when `we`=0.
- **Throughput:** one accept per cycle. Back-to-back writes produce `we` continuously high.
- **`ld_err`:** registered, asserted in cycle N+1, same timing as a write.
- **Reset values:** `we`=0, `addr`=0, `d`=0, `ld_err`=0, `retire_cnt`=0, `starve`=0.
  - Ready outputs follow the valids combinationally, also during reset.
  - Handshakes completing while `clr`=1 are discarded and not counted.
- **Reset mid-operation:** a pending N+1 write is cancelled immediately (asynchronous). It is never replayed.

## Configuration
- **`WB_BYPASS_EN` defined:** adds outputs `fwd_valid` (1), `fwd_rd` (5) and `fwd_data` (XLEN), combinational from the winning channel in the accept cycle.
  - `fwd_valid`=1 only for a non-x0 write-producing handshake.
  - Lets decode forward one cycle early.
- **Undefined:** these ports are absent. Behaviour is otherwise identical.

## Structure
- **Shared package `rv32i_pkg`:**
  - Load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
  - `REG_ADDR_W`=5.
  - `wb_src_t` enum (`WB_NONE`, `WB_ALU`, `WB_LD`).
- **Sub-module `load_align`:** combinational. Takes funct3, addr_lo and rdata; outputs formatted data and an err flag. It is instantiated once.

## Test plan
- ALU only: `alu_rd`=5, `alu_data`=0x1234_5678 → `we`=1, `addr`=5, `d`=0x1234_5678 next cycle; `retire_cnt`=1.
- Load formatting: `ld_rdata`=0x80FF_7F01 with LB@3 → `d`=0xFFFF_FF80; LBU@3 → 0x0000_0080; LH@2 → 0xFFFF_80FF; LHU@0 → 0x0000_7F01; LW@0 → 0x80FF_7F01.
- Contention: both valid continuously, STARVE_MAX=4 → grants follow L,L,L,L,A repeating; `we` is high every cycle.
- Errors: LW with `ld_addr_lo`=2, then funct3=011 → `ld_err` pulses twice, `we` stays 0, `retire_cnt`+=2.
- x0 suppression: ALU result to rd=0 → `we`=0, `retire_cnt` increments; with `WB_BYPASS_EN`, `fwd_valid`=0.
- Reset mid-stream: assert `clr` between an accept and its write cycle → `we` drops to 0 immediately, `retire_cnt`=0, no write after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the write-back unit: load funct3 codes,
// register address width and the write-back source selector.
package rv32i_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LD   = 2'd2
  } wb_src_t;

endpackage

// File: rtl/wb_unit_if.sv
// Write-back bus: ALU and load result handshakes plus the register file write port.
// The slave side is the write-back unit; the master side is the producers/register file.
interface wb_if
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [2:0]            ld_funct3;
  logic [1:0]            ld_addr_lo;
  logic [XLEN-1:0]       ld_rdata;

  logic                  we;
  logic [REG_ADDR_W-1:0] addr;
  logic [XLEN-1:0]       d;
  logic                  ld_err;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    output alu_ready, ld_ready, we, addr, d, ld_err
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    input  alu_ready, ld_ready, we, addr, d, ld_err
  );
endinterface

// File: rtl/wb_unit_load_align.sv
// Load lane select and sign/zero extension for RV32I loads; flags illegal
// funct3 codes and misaligned halfword/word accesses.
module load_align
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            err
);
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  always_comb begin
    b_sel = '0;
    case (addr_lo)
      2'd0:    b_sel = rdata[7:0];
      2'd1:    b_sel = rdata[15:8];
      2'd2:    b_sel = rdata[23:16];
      default: b_sel = rdata[31:24];
    endcase
    h_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){b_sel[7]}}, b_sel};
      F3_LH:  begin
        data = {{(XLEN-16){h_sel[15]}}, h_sel};
        err  = addr_lo[0];
      end
      F3_LW:  begin
        data = rdata;
        err  = (addr_lo != 2'd0);
      end
      F3_LBU: data = {{(XLEN-8){1'b0}}, b_sel};
      F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, h_sel};
        err  = addr_lo[0];
      end
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/wb_unit.sv
// Register-file write-back unit: arbitrates ALU/load results (load first, with an
// ALU starvation guard) and issues one registered write per cycle. Optional macro WB_BYPASS_EN.
module wb_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  wb_if.slave                   bus,
  output logic [CNT_W-1:0]      retire_cnt
`ifdef WB_BYPASS_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data
`endif
);
  logic [3:0]            starve_q, starve_d;
  logic                  alu_prio, alu_rdy, ld_rdy;
  wb_src_t               src;
  logic [XLEN-1:0]       ld_fmt, win_data;
  logic [REG_ADDR_W-1:0] win_rd;
  logic                  ld_bad, wr_d, err_d;

  logic                  we_q, ld_err_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       d_q;
  logic [CNT_W-1:0]      cnt_q;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (bus.ld_funct3),
    .addr_lo (bus.ld_addr_lo),
    .rdata   (bus.ld_rdata),
    .data    (ld_fmt),
    .err     (ld_bad)
  );

  // Starve only reaches STARVE_MAX while the ALU keeps losing, so the guard never overshoots.
  assign alu_prio = (starve_q == 4'(STARVE_MAX));
  assign alu_rdy  = bus.alu_valid & (~bus.ld_valid | alu_prio);
  assign ld_rdy   = bus.ld_valid & ~(bus.alu_valid & alu_prio);
  assign starve_d = (bus.alu_valid && !alu_rdy) ? starve_q + 4'd1 : 4'd0;

  always_comb begin
    src      = WB_NONE;
    win_rd   = '0;
    win_data = '0;
    wr_d     = 1'b0;
    err_d    = 1'b0;
    if (alu_rdy) src = WB_ALU;
    else if (ld_rdy) src = WB_LD;
    case (src)
      WB_ALU: begin
        win_rd   = bus.alu_rd;
        win_data = bus.alu_data;
        wr_d     = (bus.alu_rd != '0);
      end
      WB_LD: begin
        win_rd   = bus.ld_rd;
        win_data = ld_fmt;
        wr_d     = (bus.ld_rd != '0) && !ld_bad;
        err_d    = ld_bad;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      ld_err_q <= 1'b0;
      addr_q   <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= wr_d;
      ld_err_q <= err_d;
      if (wr_d) begin
        addr_q <= win_rd;
        d_q    <= win_data;
      end
      if (src != WB_NONE) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.alu_ready = alu_rdy;
  assign bus.ld_ready  = ld_rdy;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.d         = d_q;
  assign bus.ld_err    = ld_err_q;
  assign retire_cnt    = cnt_q;

`ifdef WB_BYPASS_EN
  assign fwd_valid = wr_d;
  assign fwd_rd    = win_rd;
  assign fwd_data  = win_data;
`endif
endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed vector table, contention/reset
// sequences and randomized traffic against a behavioural model.
module tb_wb_unit;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic clr;
  logic [31:0] retire_cnt;
  wb_if #(.XLEN(32)) bus ();

`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  wb_unit #(.XLEN(32), .STARVE_MAX(STARVE_MAX), .CNT_W(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .bus        (bus.slave),
    .retire_cnt (retire_cnt)
`ifdef WB_BYPASS_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model state
  int unsigned m_starve;
  logic [31:0] m_cnt;
  logic [4:0]  m_addr;
  logic [31:0] m_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void ref_load(input logic [2:0] f3, input logic [1:0] a,
                                   input logic [31:0] w, output bit err, output logic [31:0] v);
    logic [31:0] b, h;
    b   = (w >> (8 * a)) & 32'hFF;
    h   = (w >> (8 * a)) & 32'hFFFF;
    err = 1'b0;
    v   = '0;
    case (f3)
      3'd0: v = (b < 128) ? b : (b | 32'hFFFF_FF00);
      3'd1: begin v = (h < 32768) ? h : (h | 32'hFFFF_0000); err = (a % 2) != 0; end
      3'd2: begin v = w; err = (a != 0); end
      3'd4: v = b;
      3'd5: begin v = h; err = (a % 2) != 0; end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                       input bit lv, input logic [4:0] lrd, input logic [2:0] lf3,
                       input logic [1:0] lalo, input logic [31:0] lrdata);
    bus.alu_valid  = av;  bus.alu_rd = ard; bus.alu_data = adata;
    bus.ld_valid   = lv;  bus.ld_rd  = lrd; bus.ld_funct3 = lf3;
    bus.ld_addr_lo = lalo; bus.ld_rdata = lrdata;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One model-checked cycle; inputs are applied just after a rising edge.
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                       input bit lv, input logic [4:0] lrd, input logic [2:0] lf3,
                       input logic [1:0] lalo, input logic [31:0] lrdata, output bit alu_won);
    bit alu_win, ld_win, nwe, nerr, lerr;
    logic [31:0] lval;
    drive(av, ard, adata, lv, lrd, lf3, lalo, lrdata);
    alu_win = av && (!lv || m_starve == STARVE_MAX);
    ld_win  = lv && !alu_win;
    nwe = 0; nerr = 0;
    ref_load(lf3, lalo, lrdata, lerr, lval);
    if (alu_win) begin
      m_cnt++;
      if (ard != 0) begin nwe = 1; m_addr = ard; m_d = adata; end
    end else if (ld_win) begin
      m_cnt++;
      if (lerr) nerr = 1;
      else if (lrd != 0) begin nwe = 1; m_addr = lrd; m_d = lval; end
    end
    m_starve = (av && !alu_win) ? m_starve + 1 : 0;
    alu_won = alu_win;
    @(negedge clk);
    chk("alu_ready", 32'(bus.alu_ready), 32'(alu_win));
    chk("ld_ready", 32'(bus.ld_ready), 32'(ld_win));
`ifdef WB_BYPASS_EN
    chk("fwd_valid", 32'(fwd_valid), 32'(nwe));
    if (nwe) chk("fwd_data", fwd_data, m_d);
`endif
    @(posedge clk); #1;
    chk("we", 32'(bus.we), 32'(nwe));
    chk("ld_err", 32'(bus.ld_err), 32'(nerr));
    chk("addr", 32'(bus.addr), 32'(m_addr));
    chk("d", bus.d, m_d);
    chk("retire_cnt", retire_cnt, m_cnt);
  endtask

  typedef struct {
    bit          av;
    logic [4:0]  ard;
    logic [31:0] adata;
    bit          lv;
    logic [4:0]  lrd;
    logic [2:0]  lf3;
    logic [1:0]  lalo;
    logic [31:0] lrdata;
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_d;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit won;
    logic [31:0] exp_cnt;
    logic [4:0]  last_addr;
    logic [31:0] last_d;

    vecs[0] = '{1, 5, 32'h1234_5678, 0, 0, 0, 0, 0,           1, 5, 32'h1234_5678, 0};
    vecs[1] = '{0, 0, 0, 1, 3, 3'b000, 2'd3, 32'h80FF_7F01,   1, 3, 32'hFFFF_FF80, 0};
    vecs[2] = '{0, 0, 0, 1, 4, 3'b100, 2'd3, 32'h80FF_7F01,   1, 4, 32'h0000_0080, 0};
    vecs[3] = '{0, 0, 0, 1, 6, 3'b001, 2'd2, 32'h80FF_7F01,   1, 6, 32'hFFFF_80FF, 0};
    vecs[4] = '{0, 0, 0, 1, 7, 3'b101, 2'd0, 32'h80FF_7F01,   1, 7, 32'h0000_7F01, 0};
    vecs[5] = '{0, 0, 0, 1, 8, 3'b010, 2'd0, 32'h80FF_7F01,   1, 8, 32'h80FF_7F01, 0};
    vecs[6] = '{0, 0, 0, 1, 9, 3'b010, 2'd2, 32'h80FF_7F01,   0, 8, 32'h80FF_7F01, 1};
    vecs[7] = '{0, 0, 0, 1, 9, 3'b011, 2'd0, 32'h80FF_7F01,   0, 8, 32'h80FF_7F01, 1};
    vecs[8] = '{1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,           0, 8, 32'h80FF_7F01, 0};

    // Reset state; readies follow valids and handshakes are dropped during reset.
    clr = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_d", bus.d, 0);
    chk("rst_ld_err", 32'(bus.ld_err), 0);
    chk("rst_cnt", retire_cnt, 0);
    drive(1, 5, 32'h55, 0, 0, 0, 0, 0);
    #1 chk("rst_alu_ready", 32'(bus.alu_ready), 1);
    @(posedge clk); #1;
    chk("rst_cnt_discard", retire_cnt, 0);
    chk("rst_we_discard", 32'(bus.we), 0);
    idle();
    clr = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    exp_cnt = 0; last_addr = 0; last_d = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].lv, vecs[i].lrd,
            vecs[i].lf3, vecs[i].lalo, vecs[i].lrdata);
      @(posedge clk); #1;
      idle();
      exp_cnt++;
      chk($sformatf("vec%0d_we", i), 32'(bus.we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_err", i), 32'(bus.ld_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_addr", i), 32'(bus.addr), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_d", i), bus.d, vecs[i].exp_d);
      chk($sformatf("vec%0d_cnt", i), retire_cnt, exp_cnt);
      if (vecs[i].exp_we) begin last_addr = vecs[i].exp_addr; last_d = vecs[i].exp_d; end
      @(posedge clk); #1;
      chk($sformatf("vec%0d_we_drop", i), 32'(bus.we), 0);
    end

    m_starve = 0; m_cnt = exp_cnt; m_addr = last_addr; m_d = last_d;

    // Contention: both channels valid every cycle -> L,L,L,L,A repeating
    for (int i = 0; i < 15; i++) begin
      cycle(1, 5'd2, 32'hA000_0000 + i, 1, 5'd1, 3'b010, 2'd0, 32'hB000_0000 + i, won);
      chk($sformatf("grant%0d", i), 32'(won), 32'((i % 5) == 4));
    end
    idle();
    @(posedge clk); #1;
    m_starve = 0;
    chk("post_contend_we", 32'(bus.we), 0);

    // Reset between accept and its write cycle
    drive(1, 5'd7, 32'hCAFE_0007, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    idle();
    chk("pre_rst_we", 32'(bus.we), 1);
    clr = 1'b1;
    #1;
    chk("mid_rst_we", 32'(bus.we), 0);
    chk("mid_rst_cnt", retire_cnt, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_write", 32'(bus.we), 0);
    end
    m_starve = 0; m_cnt = 0; m_addr = 0; m_d = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit av, lv;
      logic [4:0] ard, lrd;
      av  = ($urandom_range(0, 9) < 7);
      lv  = ($urandom_range(0, 9) < 7);
      ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cycle(av, ard, $urandom, lv, lrd, 3'($urandom), 2'($urandom), $urandom, won);
    end
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
